// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Optional macro MDU_FAST_MUL_EN: single-step MULT/MULTU; division stays iterative.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [2:0]       Op,
    input  logic             Start,
    input  logic             Cancel,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_orig_q;
    logic               is_div_q, neg_q, neg_rem_q, divzero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH-1:0] acc_d, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    always_comb begin
        signed_op = (Op == OP_MULT) || (Op == OP_DIV);
        a_mag     = (signed_op && BusA[WIDTH-1]) ? -BusA : BusA;
        b_mag     = (signed_op && BusB[WIDTH-1]) ? -BusB : BusB;

        // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
        div_diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_d = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end

`ifdef MDU_FAST_MUL_EN
        prod_fix = is_div_q ? acc_q
                            : (neg_q ? -(opnd_q * acc_q[WIDTH-1:0]) : (opnd_q * acc_q[WIDTH-1:0]));
`else
        prod_fix = neg_q ? -acc_q : acc_q;
`endif
        quot_fix = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (divzero_q) begin
            res_hi = a_orig_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_orig_q  <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        if (Op[2] == 1'b0) begin
                            is_div_q  <= Op[1];
                            neg_q     <= signed_op && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
                            neg_rem_q <= signed_op && BusA[WIDTH-1];
                            divzero_q <= Op[1] && (BusB == '0);
                            a_orig_q  <= BusA;
                            acc_q     <= {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
                            opnd_q    <= Op[1] ? b_mag : a_mag;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_CALC;
                        end else if (Op == OP_MTHI) begin
                            hi_q <= BusA;
                        end else if (Op == OP_MTLO) begin
                            lo_q <= BusA;
                        end
                    end
                end
                S_CALC: begin
                    if (Cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef MDU_FAST_MUL_EN
                    end else if (!is_div_q) begin
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    // A flush arriving on the writeback edge still wins.
                    if (!Cancel) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;
endmodule
